// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and lane state encoding for the buffered 1-to-4 demux
// Optional feature macro: DEMUX_LANE_COUNT_EN (per-lane drain counters)
package demux_pkg;
    localparam int LANES   = 4;
    localparam int SEL_W   = 2;
    localparam int COUNT_W = 8;
    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_t;
endpackage

// File: rtl/demux_lane_buffer.sv
// demux_lane_buffer: one-entry register slice holding a single word for one output lane
// Ports: clk, reset (async, active-high), load (accept data_in this edge),
//        ready (consumer takes the word), data_in, valid/data (holding register),
//        count (completed drains, only with DEMUX_LANE_COUNT_EN)
module demux_lane_buffer
    import demux_pkg::*;
#(
    parameter int N_BITS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              ready,
    input  logic [N_BITS-1:0] data_in,
    output logic              valid,
    output logic [N_BITS-1:0] data
`ifdef DEMUX_LANE_COUNT_EN
    ,
    output logic [COUNT_W-1:0] count
`endif
);
    lane_state_t state, state_next;
    logic        drain;

    assign valid = (state == LANE_FULL);
    assign drain = valid & ready;

    // A load wins over a drain so a simultaneous drain+load stays FULL with the new word.
    always_comb begin
        state_next = state;
        state_next = load ? LANE_FULL : (drain ? LANE_EMPTY : state);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LANE_EMPTY;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     data <= '0;
        else if (load) data <= data_in;
    end

`ifdef DEMUX_LANE_COUNT_EN
    // Natural 8-bit wrap gives 255 -> 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      count <= '0;
        else if (drain) count <= count + 1'b1;
    end
`endif
endmodule

// File: rtl/demux_1_to_4_buffered.sv
// demux_1_to_4_buffered: steers one valid/ready stream into four independently draining lanes
// Ports: clk, reset (async, active-high), Selector (destination lane), In_Valid/In_Data/In_Ready
//        (input stream), Out_Valid/Out_Ready (per-lane handshake), Out_Data_0..3 (lane registers),
//        Out_Count_0..3 (per-lane drain counts, only with DEMUX_LANE_COUNT_EN)
module demux_1_to_4_buffered
    import demux_pkg::*;
#(
    parameter int N_BITS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEL_W-1:0]  Selector,
    input  logic              In_Valid,
    input  logic [N_BITS-1:0] In_Data,
    output logic              In_Ready,
    output logic [LANES-1:0]  Out_Valid,
    input  logic [LANES-1:0]  Out_Ready,
    output logic [N_BITS-1:0] Out_Data_0,
    output logic [N_BITS-1:0] Out_Data_1,
    output logic [N_BITS-1:0] Out_Data_2,
    output logic [N_BITS-1:0] Out_Data_3
`ifdef DEMUX_LANE_COUNT_EN
    ,
    output logic [COUNT_W-1:0] Out_Count_0,
    output logic [COUNT_W-1:0] Out_Count_1,
    output logic [COUNT_W-1:0] Out_Count_2,
    output logic [COUNT_W-1:0] Out_Count_3
`endif
);
    logic [LANES-1:0]             load;
    logic [LANES-1:0][N_BITS-1:0] lane_data;
`ifdef DEMUX_LANE_COUNT_EN
    logic [LANES-1:0][COUNT_W-1:0] lane_count;
`endif

    // Only the addressed lane gates acceptance; a draining lane passes a new word through.
    assign In_Ready = ~Out_Valid[Selector] | Out_Ready[Selector];

    genvar i;
    generate
        for (i = 0; i < LANES; i++) begin : g_lane
            assign load[i] = In_Valid & In_Ready & (Selector == SEL_W'(i));
            demux_lane_buffer #(.N_BITS(N_BITS)) u_lane (
                .clk     (clk),
                .reset   (reset),
                .load    (load[i]),
                .ready   (Out_Ready[i]),
                .data_in (In_Data),
                .valid   (Out_Valid[i]),
                .data    (lane_data[i])
`ifdef DEMUX_LANE_COUNT_EN
                ,
                .count   (lane_count[i])
`endif
            );
        end
    endgenerate

    assign Out_Data_0 = lane_data[0];
    assign Out_Data_1 = lane_data[1];
    assign Out_Data_2 = lane_data[2];
    assign Out_Data_3 = lane_data[3];
`ifdef DEMUX_LANE_COUNT_EN
    assign Out_Count_0 = lane_count[0];
    assign Out_Count_1 = lane_count[1];
    assign Out_Count_2 = lane_count[2];
    assign Out_Count_3 = lane_count[3];
`endif
endmodule

// File: tb/tb_demux_1_to_4_buffered.sv
// tb_demux_1_to_4_buffered: directed self-checking bench for the buffered 1-to-4 demux
module tb_demux_1_to_4_buffered;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  Selector;
    logic        In_Valid;
    logic [31:0] In_Data;
    logic        In_Ready;
    logic [3:0]  Out_Valid;
    logic [3:0]  Out_Ready;
    logic [31:0] Out_Data_0, Out_Data_1, Out_Data_2, Out_Data_3;
`ifdef DEMUX_LANE_COUNT_EN
    logic [7:0]  Out_Count_0, Out_Count_1, Out_Count_2, Out_Count_3;
`endif
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    demux_1_to_4_buffered #(.N_BITS(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .Selector   (Selector),
        .In_Valid   (In_Valid),
        .In_Data    (In_Data),
        .In_Ready   (In_Ready),
        .Out_Valid  (Out_Valid),
        .Out_Ready  (Out_Ready),
        .Out_Data_0 (Out_Data_0),
        .Out_Data_1 (Out_Data_1),
        .Out_Data_2 (Out_Data_2),
        .Out_Data_3 (Out_Data_3)
`ifdef DEMUX_LANE_COUNT_EN
        ,
        .Out_Count_0(Out_Count_0),
        .Out_Count_1(Out_Count_1),
        .Out_Count_2(Out_Count_2),
        .Out_Count_3(Out_Count_3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; Selector = 2'd0; In_Valid = 1'b0; In_Data = '0; Out_Ready = 4'b0000;
        step();
        check("rst_valid", {28'd0, Out_Valid}, 32'h0);
        check("rst_ready", {31'd0, In_Ready}, 32'h1);
        check("rst_data0", Out_Data_0, 32'h0);
        reset = 1'b0;
        step();

        // single transfer to lane 2, then hold under back-pressure
        Selector = 2'd2; In_Data = 32'hDEADBEEF; In_Valid = 1'b1;
        #1 check("single_ready", {31'd0, In_Ready}, 32'h1);
        step();
        In_Valid = 1'b0; In_Data = 32'h0;
        check("single_valid", {28'd0, Out_Valid}, 32'h4);
        check("single_data", Out_Data_2, 32'hDEADBEEF);
        for (int k = 0; k < 5; k++) begin
            step();
            check("hold_valid", {28'd0, Out_Valid}, 32'h4);
            check("hold_data", Out_Data_2, 32'hDEADBEEF);
        end

        // back-pressure on lane 1, then retarget to lane 3
        Selector = 2'd1; In_Data = 32'h11; In_Valid = 1'b1;
        step();
        In_Data = 32'h22;
        #1 check("bp_ready", {31'd0, In_Ready}, 32'h0);
        step();
        check("bp_data1", Out_Data_1, 32'h11);
        Selector = 2'd3;
        #1 check("retarget_ready", {31'd0, In_Ready}, 32'h1);
        step();
        In_Valid = 1'b0;
        check("retarget_valid", {28'd0, Out_Valid}, 32'he);
        check("retarget_data3", Out_Data_3, 32'h22);

        // concurrent drain of lane 3 with drain+load on lane 0
        Selector = 2'd0; In_Data = 32'h5A; In_Valid = 1'b1;
        step();
        check("all_full", {28'd0, Out_Valid}, 32'hf);
        Out_Ready = 4'b1001; In_Data = 32'hA5;
        #1 check("dl_ready", {31'd0, In_Ready}, 32'h1);
        step();
        In_Valid = 1'b0; Out_Ready = 4'b0000;
        check("dl_valid", {28'd0, Out_Valid}, 32'h7);
        check("dl_data0", Out_Data_0, 32'hA5);

        // ready on an empty lane does nothing
        Out_Ready = 4'b1000;
        step();
        check("empty_ready", {28'd0, Out_Valid}, 32'h7);

        // full-throughput pass-through on lane 0
        Out_Ready = 4'b1111; Selector = 2'd0; In_Valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            In_Data = k;
            #1 check("pt_ready", {31'd0, In_Ready}, 32'h1);
            step();
            check("pt_valid0", {31'd0, Out_Valid[0]}, 32'h1);
            check("pt_data0", Out_Data_0, k);
        end
        In_Valid = 1'b0;
        step();
        check("pt_empty", {28'd0, Out_Valid}, 32'h0);

        // reset mid-operation with lanes 0 and 2 full
        Out_Ready = 4'b0000; In_Valid = 1'b1; Selector = 2'd0; In_Data = 32'h100;
        step();
        Selector = 2'd2; In_Data = 32'h200;
        step();
        In_Valid = 1'b0;
        check("pre_rst_valid", {28'd0, Out_Valid}, 32'h5);
        #2 reset = 1'b1;
        #1 check("async_valid", {28'd0, Out_Valid}, 32'h0);
        check("async_data0", Out_Data_0, 32'h0);
        check("async_data2", Out_Data_2, 32'h0);
        #1 reset = 1'b0;
        #1 check("post_rst_ready", {31'd0, In_Ready}, 32'h1);
        step();
        check("post_rst_valid", {28'd0, Out_Valid}, 32'h0);

`ifdef DEMUX_LANE_COUNT_EN
        check("cnt_rst1", {24'd0, Out_Count_1}, 32'h0);
        Out_Ready = 4'b0010; Selector = 2'd1; In_Valid = 1'b1; In_Data = 32'h7;
        repeat (257) step();
        In_Valid = 1'b0;
        step();
        check("cnt1", {24'd0, Out_Count_1}, 32'h1);
        check("cnt0", {24'd0, Out_Count_0}, 32'h0);
        check("cnt2", {24'd0, Out_Count_2}, 32'h0);
        check("cnt3", {24'd0, Out_Count_3}, 32'h0);
        #2 reset = 1'b1;
        #1 check("cnt_rst_after", {24'd0, Out_Count_1}, 32'h0);
        reset = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
